// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_mem_pkg
// Shared access-size encodings, responder states and access legality helpers.
// Revision: 1.0
// ============================================================================
package cpu_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Stores only know the signed sizes; loads additionally accept BU/HU.
  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic [2:0] f3_effective(input logic write, input logic [2:0] f3);
    return f3_legal(write, f3) ? f3 : F3_W;
  endfunction

  function automatic logic dmem_access_err(input logic write, input logic [2:0] f3,
                                           input logic [1:0] addr_lo);
    if (!f3_legal(write, f3)) return 1'b1;
    case (f3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lane_align
// Combinational lane steering: load extract/extend and store byte enables.
// Revision: 1.0
// ============================================================================
module dmem_lane_align
  import cpu_mem_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep
);

  logic [2:0]  eff_f3;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    eff_f3    = f3_effective(write, func3);
    half_v    = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (addr_lo)
      2'd0:    byte_v = rword[7:0];
      2'd1:    byte_v = rword[15:8];
      2'd2:    byte_v = rword[23:16];
      default: byte_v = rword[31:24];
    endcase

    load_data = rword;
    byte_en   = 4'b1111;
    wdata_rep = wdata;
    case (eff_f3)
      F3_B: begin
        load_data = {{24{byte_v[7]}}, byte_v};
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_BU: load_data = {24'd0, byte_v};
      F3_H: begin
        load_data = {{16{half_v[15]}}, half_v};
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      F3_HU: load_data = {16'd0, half_v};
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// CPU data-memory responder with WAIT_CYCLES wait states before each access.
// Option  : DMEM_MISALIGN_CHECK_EN flags misaligned / illegal-size accesses.
// Revision: 1.0
// ============================================================================
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_t   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    func3_q, func3_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          sel_write;
  logic [AW+1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic [2:0]    sel_func3;
  logic          access, access_err;
  logic [31:0]   load_data, wdata_rep;
  logic [3:0]    byte_en;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AW+2];

  // With zero wait states the access happens on the accept edge, straight from the ports.
  assign sel_write = (state_q == IDLE) ? req_write          : write_q;
  assign sel_addr  = (state_q == IDLE) ? req_addr[AW+1:0]   : addr_q;
  assign sel_wdata = (state_q == IDLE) ? req_wdata          : wdata_q;
  assign sel_func3 = (state_q == IDLE) ? req_func3          : func3_q;

  assign access = ((state_q == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd0));

`ifdef DMEM_MISALIGN_CHECK_EN
  assign access_err = dmem_access_err(sel_write, sel_func3, sel_addr[1:0]);
`else
  assign access_err = 1'b0;
`endif

  dmem_lane_align u_lane (
    .write     (sel_write),
    .func3     (sel_func3),
    .addr_lo   (sel_addr[1:0]),
    .rword     (mem[sel_addr[AW+1:2]]),
    .wdata     (sel_wdata),
    .load_data (load_data),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    func3_d = func3_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
          func3_d = req_func3;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (access) begin
      rdata_d = (sel_write || access_err) ? 32'd0 : load_data;
      err_d   = access_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      func3_q <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      func3_q <= func3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; a store racing a reset edge is suppressed.
  always_ff @(posedge clk) begin
    if (access && sel_write && !access_err && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[sel_addr[AW+1:2]][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Randomised and directed bench for dmem_responder against a byte-array model.
// Revision: 1.0
// ============================================================================
module tb_dmem_responder;

  localparam int WAIT_CYC = 1;
  localparam int TIMEOUT  = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_func3 = 3'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  // Byte-addressed image of the 1 KiB array; upper address bits alias.
  logic [7:0] mb [0:1023];

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAIT_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_func3 (req_func3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic void ref_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                     input logic [2:0] f, output logic [31:0] rd, output logic er);
    int     size;
    bit     sgn;
    bit     legal;
    int     base;
    longint val;
    legal = w ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 4;
    sgn   = 1'b0;
    if (legal) begin
      case (f)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 4;
      endcase
    end
    base = int'(a[9:0]);
    er   = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (!legal || (base % size) != 0) er = 1'b1;
`endif
    base = base - (base % size);
    rd   = 32'd0;
    if (er) return;
    if (w) begin
      for (int i = 0; i < size; i++) mb[base + i] = d[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < size; i++) val = val + (longint'(mb[base + i]) << (8 * i));
      if (sgn && val >= (longint'(1) << (8 * size - 1))) val = val - (longint'(1) << (8 * size));
      rd = val[31:0];
    end
  endfunction

  // Issues one request and waits (bounded) for its response; leaves it pending.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_func3 = f;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic release_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b rdata=%h err=%b want rdy=1 vld=0 rdata=0 err=0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_init();
    logic [31:0] rd, erd, d;
    logic        er, eer;
    int          lat;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      ref_access(1'b1, 32'(i * 4), d, 3'd2, erd, eer);
      txn(1'b1, 32'(i * 4), d, 3'd2, rd, er, lat);
      total++;
      if (rd !== erd || er !== eer || lat !== WAIT_CYC) begin
        bad++;
        $display("FAIL init_sw[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                 i, rd, er, lat, erd, eer, WAIT_CYC);
      end
      release_rsp();
    end
  endtask

  task automatic test_directed();
    logic        t_w  [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_a  [10] = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h10, 32'h10};
    logic [31:0] t_d  [10] = '{32'hDEADBEEF, 32'h0, 32'h80, 32'h0, 32'h0, 32'h0, 32'h1234, 32'h0, 32'h0, 32'h0};
    logic [2:0]  t_f  [10] = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd1, 3'd5, 3'd2};
    logic [31:0] t_e  [10] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hFFFFFF80, 32'h00000080, 32'h80ADBEEF,
                               32'h0, 32'h00001234, 32'h0000BEEF, 32'h1234BEEF};
    logic [31:0] rd, mrd;
    logic        er, mer;
    int          lat;
    for (int i = 0; i < 10; i++) begin
      ref_access(t_w[i], t_a[i], t_d[i], t_f[i], mrd, mer);
      txn(t_w[i], t_a[i], t_d[i], t_f[i], rd, er, lat);
      total++;
      if (rd !== t_e[i] || er !== 1'b0 || lat !== WAIT_CYC) begin
        bad++;
        $display("FAIL directed[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=0 lat=%0d",
                 i, rd, er, lat, t_e[i], WAIT_CYC);
      end
      release_rsp();
    end
  endtask

  task automatic test_misalign();
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        t_w  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_a  [4] = '{32'h11, 32'h11, 32'h10, 32'h10};
    logic [2:0]  t_f  [4] = '{3'd2, 3'd1, 3'd3, 3'd2};
    logic [31:0] t_e  [4] = '{32'h0, 32'h0, 32'h0, 32'h1234BEEF};
    logic        t_er [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
    logic        t_w  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_a  [4] = '{32'h11, 32'h13, 32'h10, 32'h413};
    logic [2:0]  t_f  [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
    logic [31:0] t_e  [4] = '{32'h1234BEEF, 32'h00001234, 32'h1234BEEF, 32'h00000012};
    logic        t_er [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    logic [31:0] rd, mrd;
    logic        er, mer;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      ref_access(t_w[i], t_a[i], 32'hFFFFFFFF, t_f[i], mrd, mer);
      txn(t_w[i], t_a[i], 32'hFFFFFFFF, t_f[i], rd, er, lat);
      total++;
      if (rd !== t_e[i] || er !== t_er[i] || lat !== WAIT_CYC) begin
        bad++;
        $display("FAIL misalign[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                 i, rd, er, lat, t_e[i], t_er[i], WAIT_CYC);
      end
      release_rsp();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, erd, rd2;
    logic        er, eer;
    int          lat;
    ref_access(1'b0, 32'h10, 32'h0, 3'd2, erd, eer);
    txn(1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat);
    total++;
    if (rd !== erd || er !== eer || lat !== WAIT_CYC) begin
      bad++;
      $display("FAIL bp_first: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
               rd, er, lat, erd, eer, WAIT_CYC);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h0;
      req_func3 = 3'd2;
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== erd || rsp_err !== eer || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdata=%h err=%b rdy=%b want vld=1 rdata=%h err=%b rdy=0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready, erd, eer);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    release_rsp();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", rsp_valid, req_ready);
    end
    ref_access(1'b0, 32'h20, 32'h0, 3'd2, erd, eer);
    txn(1'b0, 32'h20, 32'h0, 3'd2, rd2, er, lat);
    total++;
    if (rd2 !== erd || er !== eer) begin
      bad++;
      $display("FAIL bp_no_accept: got rdata=%h err=%b want rdata=%h err=%b", rd2, er, erd, eer);
    end
    release_rsp();
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd, erd;
    logic        er, eer;
    int          lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h55;
    req_func3 = 3'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL midop_reset: got rdy=%b vld=%b rdata=%h err=%b want rdy=1 vld=0 rdata=0 err=0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_access(1'b0, 32'h20, 32'h0, 3'd2, erd, eer);
    txn(1'b0, 32'h20, 32'h0, 3'd2, rd, er, lat);
    total++;
    if (rd !== erd || er !== eer || lat !== WAIT_CYC) begin
      bad++;
      $display("FAIL midop_old_data: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
               rd, er, lat, erd, eer, WAIT_CYC);
    end
    release_rsp();
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d;
    logic        er, eer, w;
    logic [2:0]  f;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      d = $urandom;
      ref_access(w, a, d, f, erd, eer);
      txn(w, a, d, f, rd, er, lat);
      total++;
      if (rd !== erd || er !== eer || lat !== WAIT_CYC) begin
        bad++;
        $display("FAIL random[%0d] w=%b f=%0d a=%h: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                 i, w, f, a, rd, er, lat, erd, eer, WAIT_CYC);
      end
      release_rsp();
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_misalign();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
